axi_protocol_monitor: RTL and testbench
=======================================

Name: axi_protocol_monitor

Overview:
- Synthesizable, parametrised AXI master-side protocol monitor for the DMA environment. Generalises the single-property read-address check.
- Passively observes AR/AW/W/R/B and checks handshake stability, burst length, outstanding limits and stall timeouts.
- Reports errors as sticky flags, a first-error code, a saturating counter and an interrupt pulse.
- Sits beside the DMA AXI port; usable in simulation and emulation.

Parameters:
- W, 32, data width of wdata.
- B, 8, burst length field width (arlen/awlen).
- MAX_OUTSTANDING, 4, max accepted-but-incomplete bursts per direction; also the AR length FIFO depth (power of 2, ≥2).
- TIMEOUT, 256, stall cycles before a timeout error; 0 disables timeout checking.
- CNT_W, 16, error counter width.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- arvalid, arready  in  1  read address handshake
- araddr  in  32  read address
- arlen  in  B  read burst length minus 1
- awvalid, awready  in  1  write address handshake
- awaddr  in  32  write address
- awlen  in  B  write burst length minus 1
- wvalid, wready, wlast  in  1  write data handshake and last
- wdata  in  W  write data
- wstrb  in  W/8  write strobes
- rvalid, rready, rlast  in  1  read data handshake and last
- bvalid, bready  in  1  write response handshake
- err_clr  in  1  clears err_vec, err_valid, err_first, err_cnt
- err_vec  out  8  sticky error flags, bit n = En
- err_valid  out  1  at least one error latched since reset/clear
- err_first  out  3  index of first latched error
- err_cnt  out  CNT_W  saturating count of error cycles
- err_irq  out  1  one-cycle pulse on any new error

Behaviour:
- Reset (areset high at a posedge): all outputs 0; AR FIFO empty; beat counter, AW outstanding counter and timeout counters 0; previous-cycle stall history cleared. No stability check on the first cycle after reset.
- Handshake: X fires when Xvalid & Xready at a posedge.
- E0 AR stability: previous cycle arvalid & !arready; current cycle !arvalid, or araddr/arlen changed.
- E1 AW stability: same rule using awaddr/awlen.
- E2 W stability: same rule using wdata/wstrb/wlast.
- AR FIFO: pushes arlen on each AR handshake, depth MAX_OUTSTANDING. Push and pop in the same cycle are legal even when full.
- E3 R burst length: R handshake with FIFO not empty, expected beats = head+1, beat = rbeat+1.
  - rlast and beat != expected: E3.
  - !rlast and beat == expected: E3, then resync as if rlast were seen.
  - On rlast or resync: pop FIFO, rbeat := 0; otherwise rbeat++.
- E4 orphan R: R handshake while FIFO empty; a same-cycle AR does not excuse it. Counter untouched.
- E5 overflow: AR handshake with FIFO full and no same-cycle pop (push dropped), or AW handshake with aw_out == MAX_OUTSTANDING and no same-cycle B.
- AW outstanding counter: +1 on AW handshake, −1 on B handshake, net 0 if both in the same cycle. Saturates; never wraps.
- E6 timeout: one counter each for AR, AW and W.
  - Counts consecutive valid & !ready cycles; resets on ready or !valid.
  - Error on the TIMEOUT-th stalled cycle, once per stall.
- E7 orphan B: B handshake while aw_out == 0 and no same-cycle AW.
- Error latching, registered, one cycle after the offending posedge:
  - new = detected bits this cycle; err_vec |= new; err_irq = |new.
  - err_cnt += 1 per cycle with |new, saturating at all-ones.
  - If !err_valid: err_first = lowest set index of new, and err_valid := 1.
- err_clr: clears err_vec, err_valid, err_first and err_cnt. A new error in the same cycle wins; it is latched after the clear, becomes err_first, and err_cnt = 1.
- areset mid-burst: everything discarded. A later R without a fresh AR flags E4.

Optional Feature:
- Macro: AXI_PROTOCOL_MONITOR_SVA_EN.
- Defined: adds concurrent assertions, one per E0–E7, with disable iff (areset). Each reports its name and $time via $error. Flag logic is unchanged.
- Undefined: no assertions; pure synthesizable flag logic only.

Test Plan:
- AR held 3 cycles with arready low, araddr changes 0x100→0x104 in cycle 2 → err_vec=0x01, err_first=0, err_cnt=1, single err_irq pulse.
- AR arlen=3, then 4 R beats with rlast on beat 4 → no error. Repeat with rlast on beat 3 → err_vec bit3, FIFO empty afterwards.
- R handshake with no prior AR → E4. A subsequent legal AR plus 1-beat R (arlen=0) → no further errors.
- MAX_OUTSTANDING=4: 5 ARs with no R → E5 on the 5th. Same-cycle 5th AR and rlast pop → no E5.
- TIMEOUT=8: wvalid high, wready low for 20 cycles → E6 exactly once, on the 8th stalled cycle. B with zero outstanding AW → E7; err_first stays 6.
- Latch errors, then err_clr in the same cycle as a new E2 → err_vec=0x04, err_first=2, err_cnt=1. Pulse areset mid-burst → all outputs 0.

Source files
------------

// File: rtl/axi_protocol_monitor.sv
// axi_protocol_monitor -- passive AXI master-side protocol checker.
// Error classes: E0/E1/E2 AR/AW/W stability while stalled, E3 R burst
// length, E4 orphan R, E5 outstanding overflow, E6 stall timeout, E7 orphan B.
// Optional: define AXI_PROTOCOL_MONITOR_SVA_EN to add one concurrent
// assertion per error class; the flag logic is identical either way.
module axi_protocol_monitor #(
  parameter int W               = 32,
  parameter int B               = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 256,
  parameter int CNT_W           = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      araddr,
  input  logic [B-1:0]     arlen,
  input  logic             awvalid,
  input  logic             awready,
  input  logic [31:0]      awaddr,
  input  logic [B-1:0]     awlen,
  input  logic             wvalid,
  input  logic             wready,
  input  logic             wlast,
  input  logic [W-1:0]     wdata,
  input  logic [W/8-1:0]   wstrb,
  input  logic             rvalid,
  input  logic             rready,
  input  logic             rlast,
  input  logic             bvalid,
  input  logic             bready,
  input  logic             err_clr,
  output logic [7:0]       err_vec,
  output logic             err_valid,
  output logic [2:0]       err_first,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_irq
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PW:0]      DEPTH   = (PW+1)'(MAX_OUTSTANDING);
  localparam logic [TW-1:0]    TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0]    TO_SAT  = TW'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  // Previous-cycle snapshots for the stability checks.
  logic            ar_stall_q, aw_stall_q, w_stall_q;
  logic [31:0]     araddr_q, awaddr_q;
  logic [B-1:0]    arlen_q, awlen_q;
  logic [W-1:0]    wdata_q;
  logic [W/8-1:0]  wstrb_q;
  logic            wlast_q;
  // AR length FIFO and R beat tracking.
  logic [B-1:0]    mem_q [MAX_OUTSTANDING];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]     fifo_cnt_q, fifo_cnt_d;
  logic [B:0]      rbeat_q, rbeat_d;
  // AW outstanding and stall timeout counters.
  logic [PW:0]     aw_out_q, aw_out_d;
  logic [TW-1:0]   to_ar_q, to_ar_d, to_aw_q, to_aw_d, to_w_q, to_w_d;
  // Error reporting state.
  logic [7:0]       err_vec_q, err_vec_d;
  logic             err_valid_q, err_valid_d;
  logic [2:0]       err_first_q, err_first_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_irq_q, err_irq_d;

  logic       ar_hs, aw_hs, r_hs, b_hs;
  logic       fifo_empty, fifo_full, push, pop, new_any;
  logic [B-1:0] fifo_head;
  logic [B:0] r_beat, r_exp;
  logic [7:0] det;

  assign ar_hs      = arvalid & arready;
  assign aw_hs      = awvalid & awready;
  assign r_hs       = rvalid & rready;
  assign b_hs       = bvalid & bready;
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == DEPTH);
  assign fifo_head  = mem_q[rd_ptr_q];
  assign r_beat     = rbeat_q + 1'b1;
  assign r_exp      = {1'b0, fifo_head} + 1'b1;
  assign new_any    = |det;

  function automatic logic [TW-1:0] to_next(input logic stall, input logic [TW-1:0] cnt);
    if (!stall)        return '0;
    if (cnt == TO_SAT) return cnt;
    return cnt + 1'b1;
  endfunction

  function automatic logic to_hit(input logic stall, input logic [TW-1:0] cnt);
    return (TIMEOUT > 0) && stall && (cnt == TO_LAST);
  endfunction

  function automatic logic [2:0] first_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  // Detect protocol violations and advance the tracking state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    det        = '0;
    push       = 1'b0;
    pop        = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    rbeat_d    = rbeat_q;
    aw_out_d   = aw_out_q;

    det[0] = ar_stall_q && (!arvalid || araddr != araddr_q || arlen != arlen_q);
    det[1] = aw_stall_q && (!awvalid || awaddr != awaddr_q || awlen != awlen_q);
    det[2] = w_stall_q  && (!wvalid  || wdata != wdata_q || wstrb != wstrb_q || wlast != wlast_q);

    if (r_hs) begin
      if (fifo_empty) begin
        det[4] = 1'b1;
      end else if (rlast) begin
        det[3] = (r_beat != r_exp);
        pop    = 1'b1;
      end else if (r_beat == r_exp) begin
        det[3] = 1'b1;  // missing rlast: resync to the next burst
        pop    = 1'b1;
      end else begin
        rbeat_d = r_beat;
      end
    end
    if (pop) begin
      rbeat_d  = '0;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (ar_hs) begin
      if (fifo_full && !pop) det[5] = 1'b1;
      else                   push   = 1'b1;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    case ({aw_hs, b_hs})
      2'b10: begin
        if (aw_out_q == DEPTH) det[5]   = 1'b1;
        else                   aw_out_d = aw_out_q + 1'b1;
      end
      2'b01: begin
        if (aw_out_q == '0) det[7]   = 1'b1;
        else                aw_out_d = aw_out_q - 1'b1;
      end
      default: aw_out_d = aw_out_q;
    endcase

    det[6] = to_hit(arvalid & ~arready, to_ar_q) |
             to_hit(awvalid & ~awready, to_aw_q) |
             to_hit(wvalid  & ~wready,  to_w_q);
    to_ar_d = to_next(arvalid & ~arready, to_ar_q);
    to_aw_d = to_next(awvalid & ~awready, to_aw_q);
    to_w_d  = to_next(wvalid  & ~wready,  to_w_q);
  end

  // Fold this cycle's detections into the sticky report; a same-cycle error beats err_clr.
  always_comb begin
    err_vec_d   = err_clr ? det : (err_vec_q | det);
    err_valid_d = err_clr ? new_any : (err_valid_q | new_any);
    err_first_d = err_clr ? 3'd0 : err_first_q;
    if (new_any && (err_clr || !err_valid_q)) err_first_d = first_idx(det);
    err_cnt_d   = err_clr ? '0 : err_cnt_q;
    if (new_any && (err_cnt_d != CNT_SAT)) err_cnt_d = err_cnt_d + 1'b1;
    err_irq_d   = new_any;
  end

  // State register with synchronous reset.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (areset) begin
      ar_stall_q  <= 1'b0;
      aw_stall_q  <= 1'b0;
      w_stall_q   <= 1'b0;
      araddr_q    <= '0;
      awaddr_q    <= '0;
      arlen_q     <= '0;
      awlen_q     <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wlast_q     <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      rbeat_q     <= '0;
      aw_out_q    <= '0;
      to_ar_q     <= '0;
      to_aw_q     <= '0;
      to_w_q      <= '0;
      err_vec_q   <= '0;
      err_valid_q <= 1'b0;
      err_first_q <= '0;
      err_cnt_q   <= '0;
      err_irq_q   <= 1'b0;
    end else begin
      ar_stall_q  <= arvalid & ~arready;
      aw_stall_q  <= awvalid & ~awready;
      w_stall_q   <= wvalid & ~wready;
      araddr_q    <= araddr;
      awaddr_q    <= awaddr;
      arlen_q     <= arlen;
      awlen_q     <= awlen;
      wdata_q     <= wdata;
      wstrb_q     <= wstrb;
      wlast_q     <= wlast;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      rbeat_q     <= rbeat_d;
      aw_out_q    <= aw_out_d;
      to_ar_q     <= to_ar_d;
      to_aw_q     <= to_aw_d;
      to_w_q      <= to_w_d;
      err_vec_q   <= err_vec_d;
      err_valid_q <= err_valid_d;
      err_first_q <= err_first_d;
      err_cnt_q   <= err_cnt_d;
      err_irq_q   <= err_irq_d;
    end
  end

  // AR length storage.
  always_ff @(posedge aclk) begin
    // NOTE: storage is not reset; fifo_cnt_q marks which entries hold valid data.
    if (push) mem_q[wr_ptr_q] <= arlen;
  end

  assign err_vec   = err_vec_q;
  assign err_valid = err_valid_q;
  assign err_first = err_first_q;
  assign err_cnt   = err_cnt_q;
  assign err_irq   = err_irq_q;

`ifdef AXI_PROTOCOL_MONITOR_SVA_EN
  a_e0_ar_stable: assert property (@(posedge aclk) disable iff (areset) !det[0])
    else $error("E0 ar_stability at %0t", $time);
  a_e1_aw_stable: assert property (@(posedge aclk) disable iff (areset) !det[1])
    else $error("E1 aw_stability at %0t", $time);
  a_e2_w_stable: assert property (@(posedge aclk) disable iff (areset) !det[2])
    else $error("E2 w_stability at %0t", $time);
  a_e3_r_len: assert property (@(posedge aclk) disable iff (areset) !det[3])
    else $error("E3 r_burst_length at %0t", $time);
  a_e4_r_orphan: assert property (@(posedge aclk) disable iff (areset) !det[4])
    else $error("E4 orphan_r at %0t", $time);
  a_e5_overflow: assert property (@(posedge aclk) disable iff (areset) !det[5])
    else $error("E5 outstanding_overflow at %0t", $time);
  a_e6_timeout: assert property (@(posedge aclk) disable iff (areset) !det[6])
    else $error("E6 stall_timeout at %0t", $time);
  a_e7_b_orphan: assert property (@(posedge aclk) disable iff (areset) !det[7])
    else $error("E7 orphan_b at %0t", $time);
`endif

endmodule

// File: tb/tb_axi_protocol_monitor.sv
// Bench for axi_protocol_monitor: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_axi_protocol_monitor;
  localparam int W       = 32;
  localparam int B       = 8;
  localparam int MAXO    = 4;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic             areset, err_clr;
  logic             arvalid, arready, awvalid, awready;
  logic [31:0]      araddr, awaddr;
  logic [B-1:0]     arlen, awlen;
  logic             wvalid, wready, wlast;
  logic [W-1:0]     wdata;
  logic [W/8-1:0]   wstrb;
  logic             rvalid, rready, rlast, bvalid, bready;
  logic [7:0]       err_vec;
  logic             err_valid, err_irq;
  logic [2:0]       err_first;
  logic [CNT_W-1:0] err_cnt;

  axi_protocol_monitor #(.W(W), .B(B), .MAX_OUTSTANDING(MAXO), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .areset(areset),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
    .rvalid(rvalid), .rready(rready), .rlast(rlast),
    .bvalid(bvalid), .bready(bready), .err_clr(err_clr),
    .err_vec(err_vec), .err_valid(err_valid), .err_first(err_first),
    .err_cnt(err_cnt), .err_irq(err_irq)
  );

  int    checks = 0, failures = 0;
  int    irq_pulses;
  string phase = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s/%s got=0x%0h exp=0x%0h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int             ar_q[$];        // outstanding read burst lengths (beats)
  int             m_rbeat, m_aw_out, m_to_ar, m_to_aw, m_to_w;
  bit             p_ar_stall, p_aw_stall, p_w_stall;
  logic [31:0]    p_araddr, p_awaddr;
  logic [B-1:0]   p_arlen, p_awlen;
  logic [W-1:0]   p_wdata;
  logic [W/8-1:0] p_wstrb;
  logic           p_wlast;
  logic [7:0]     m_vec;
  bit             m_valid, m_irq;
  int             m_first, m_cnt;

  function automatic void model_reset();
    ar_q.delete();
    m_rbeat = 0; m_aw_out = 0; m_to_ar = 0; m_to_aw = 0; m_to_w = 0;
    p_ar_stall = 0; p_aw_stall = 0; p_w_stall = 0;
    m_vec = 0; m_valid = 0; m_irq = 0; m_first = 0; m_cnt = 0;
  endfunction

  function automatic void model_step();
    logic [7:0] nw;
    bit popped;
    nw = 0;
    popped = 0;
    if (areset) begin
      model_reset();
      return;
    end
    if (p_ar_stall && (!arvalid || araddr != p_araddr || arlen != p_arlen)) nw[0] = 1;
    if (p_aw_stall && (!awvalid || awaddr != p_awaddr || awlen != p_awlen)) nw[1] = 1;
    if (p_w_stall && (!wvalid || wdata != p_wdata || wstrb != p_wstrb || wlast != p_wlast)) nw[2] = 1;
    if (rvalid && rready) begin
      if (ar_q.size() == 0) nw[4] = 1;
      else begin
        m_rbeat++;
        if (rlast || m_rbeat == ar_q[0]) begin
          if (m_rbeat != ar_q[0] || !rlast) nw[3] = 1;
          void'(ar_q.pop_front());
          m_rbeat = 0;
          popped = 1;
        end
      end
    end
    if (arvalid && arready) begin
      if (ar_q.size() >= MAXO) nw[5] = 1;
      else ar_q.push_back(int'(arlen) + 1);
    end
    if ((awvalid && awready) && !(bvalid && bready)) begin
      if (m_aw_out == MAXO) nw[5] = 1; else m_aw_out++;
    end
    if ((bvalid && bready) && !(awvalid && awready)) begin
      if (m_aw_out == 0) nw[7] = 1; else m_aw_out--;
    end
    m_to_ar = (arvalid && !arready) ? m_to_ar + 1 : 0;
    m_to_aw = (awvalid && !awready) ? m_to_aw + 1 : 0;
    m_to_w  = (wvalid && !wready)   ? m_to_w + 1  : 0;
    if (m_to_ar == TIMEOUT || m_to_aw == TIMEOUT || m_to_w == TIMEOUT) nw[6] = 1;
    if (err_clr) begin
      m_vec = 0; m_valid = 0; m_first = 0; m_cnt = 0;
    end
    if (nw != 0) begin
      m_vec = m_vec | nw;
      if (!m_valid) begin
        m_valid = 1;
        m_first = 0;
        while (!nw[m_first]) m_first++;
      end
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    m_irq = (nw != 0);
    p_ar_stall = arvalid && !arready; p_araddr = araddr; p_arlen = arlen;
    p_aw_stall = awvalid && !awready; p_awaddr = awaddr; p_awlen = awlen;
    p_w_stall  = wvalid && !wready;   p_wdata = wdata; p_wstrb = wstrb; p_wlast = wlast;
    if (popped) m_rbeat = 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge aclk);
    model_step();
    #1;
    check("err_vec", err_vec, m_vec);
    check("err_valid", err_valid, m_valid);
    check("err_first", err_first, m_first);
    check("err_cnt", err_cnt, m_cnt);
    check("err_irq", err_irq, m_irq);
    if (err_irq === 1'b1) irq_pulses++;
  endtask

  task automatic idle();
    areset = 0; err_clr = 0;
    arvalid = 0; arready = 0; awvalid = 0; awready = 0;
    wvalid = 0; wready = 0; rvalid = 0; rready = 0; rlast = 0;
    bvalid = 0; bready = 0;
  endtask

  task automatic do_reset();
    idle();
    areset = 1;
    cycle();
    areset = 0;
    check("rst_vec", err_vec, 0);
    check("rst_valid", err_valid, 0);
    check("rst_first", err_first, 0);
    check("rst_cnt", err_cnt, 0);
    check("rst_irq", err_irq, 0);
    irq_pulses = 0;
  endtask

  task automatic send_ar(input int len);
    arvalid = 1; arready = 1; arlen = B'(len);
    cycle();
    arvalid = 0; arready = 0;
  endtask

  task automatic send_r(input bit last);
    rvalid = 1; rready = 1; rlast = last;
    cycle();
    rvalid = 0; rready = 0; rlast = 0;
  endtask

  task automatic send_b();
    bvalid = 1; bready = 1;
    cycle();
    bvalid = 0; bready = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits, hit_at;
    araddr = 0; arlen = 0; awaddr = 0; awlen = 0;
    wdata = 0; wstrb = 0; wlast = 0;
    idle();
    areset = 1;
    model_reset();

    phase = "reset";
    do_reset();

    // AR address changes while stalled.
    phase = "ar_stable";
    arvalid = 1; arready = 0; araddr = 32'h100; arlen = 0;
    cycle();
    araddr = 32'h104;
    cycle();
    cycle();
    arready = 1;
    cycle();
    arvalid = 0; arready = 0;
    cycle();
    check("vec", err_vec, 8'h01);
    check("first", err_first, 0);
    check("cnt", err_cnt, 1);
    check("irq_pulses", irq_pulses, 1);

    // Correct 4-beat burst, then a burst with early rlast.
    phase = "r_len";
    do_reset();
    send_ar(3);
    repeat (3) send_r(0);
    send_r(1);
    check("good_burst", err_vec, 8'h00);
    send_ar(3);
    send_r(0); send_r(0); send_r(1);
    check("short_burst", err_vec, 8'h08);
    check("short_first", err_first, 3);
    send_r(1);
    check("fifo_empty_after", err_vec, 8'h18);

    // Orphan R, then a legal single-beat read.
    phase = "r_orphan";
    do_reset();
    send_r(1);
    check("vec", err_vec, 8'h10);
    check("first", err_first, 4);
    send_ar(0);
    send_r(1);
    check("vec_after", err_vec, 8'h10);
    check("cnt_after", err_cnt, 1);

    // Outstanding read overflow, and the same-cycle push/pop case.
    phase = "ar_overflow";
    do_reset();
    repeat (4) send_ar(0);
    check("four_ok", err_vec, 8'h00);
    send_ar(0);
    check("fifth", err_vec, 8'h20);
    check("fifth_first", err_first, 5);
    do_reset();
    repeat (4) send_ar(0);
    arvalid = 1; arready = 1; arlen = 0; rvalid = 1; rready = 1; rlast = 1;
    cycle();
    idle();
    check("push_pop_full", err_vec, 8'h00);
    repeat (4) send_r(1);
    check("drain_four", err_vec, 8'h00);
    send_r(1);
    check("drain_fifth", err_vec, 8'h10);

    // W stall timeout, then orphan B.
    phase = "timeout";
    do_reset();
    wvalid = 1; wready = 0; wdata = 32'hCAFE_0001; wstrb = '1; wlast = 1;
    hits = 0; hit_at = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (err_irq === 1'b1) begin
        hits++;
        hit_at = i;
      end
    end
    check("e6_hits", hits, 1);
    check("e6_cycle", hit_at, TIMEOUT);
    wready = 1;
    cycle();
    wvalid = 0; wready = 0;
    check("e6_vec", err_vec, 8'h40);
    send_b();
    check("e7_vec", err_vec, 8'hC0);
    check("e7_first", err_first, 6);

    // Clear racing a new E2, then reset mid-burst.
    phase = "clear";
    do_reset();
    send_r(1);
    send_b();
    check("pre_clear_cnt", err_cnt, 2);
    wvalid = 1; wready = 0; wdata = 32'h1111_0000;
    cycle();
    wdata = 32'h2222_0000; err_clr = 1;
    cycle();
    err_clr = 0;
    check("clr_vec", err_vec, 8'h04);
    check("clr_first", err_first, 2);
    check("clr_cnt", err_cnt, 1);
    wready = 1;
    cycle();
    wvalid = 0; wready = 0;
    send_ar(3);
    send_r(0); send_r(0);
    phase = "mid_reset";
    do_reset();
    send_r(0);
    check("r_after_reset", err_vec, 8'h10);

    // Error counter saturation.
    phase = "saturate";
    do_reset();
    rvalid = 1; rready = 1; rlast = 0;
    repeat (20) cycle();
    idle();
    check("cnt_sat", err_cnt, CNT_MAX);

    // Randomized traffic against the model.
    phase = "random";
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      bit starve;
      starve = ((n / 150) % 3) == 2;
      areset  = ($urandom_range(0, 99) == 0);
      err_clr = ($urandom_range(0, 31) == 0);
      arvalid = ($urandom_range(0, 99) < (starve ? 95 : 60));
      awvalid = ($urandom_range(0, 99) < (starve ? 95 : 60));
      wvalid  = ($urandom_range(0, 99) < (starve ? 95 : 60));
      arready = ($urandom_range(0, 99) < (starve ? 10 : 50));
      awready = ($urandom_range(0, 99) < (starve ? 10 : 50));
      wready  = ($urandom_range(0, 99) < (starve ? 10 : 50));
      rvalid  = ($urandom_range(0, 99) < 50);
      rready  = ($urandom_range(0, 99) < 70);
      rlast   = ($urandom_range(0, 99) < 35);
      bvalid  = ($urandom_range(0, 99) < 40);
      bready  = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 3) == 0) araddr = 32'($urandom_range(0, 3)) << 2;
      if ($urandom_range(0, 3) == 0) awaddr = 32'($urandom_range(0, 3)) << 2;
      if ($urandom_range(0, 3) == 0) arlen  = B'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) awlen  = B'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) wdata  = $urandom;
      if ($urandom_range(0, 7) == 0) wstrb  = W/8'($urandom);
      if ($urandom_range(0, 7) == 0) wlast  = 1'($urandom);
      cycle();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
